ram1clk1ino: RTL and testbench
==============================

RAM1CLK1INO -- requirements
Module: ram1clk1ino

Interface
REQ-001 SHALL have parameter SZ, default 2, entry count (>=2).
REQ-002 SHALL have parameter DW, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter NRD, default 2, read-port count (1..8).
REQ-004 SHALL have parameter CLRONRST, default 1; 1 = zero whole array after reset.
REQ-005 SHALL have parameter SRCFILE, default "", hex init file loaded at elaboration when non-empty.
REQ-006 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port rst_i, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have port clr_i, input, 1, request full-array clear.
REQ-009 SHALL have port busy_o, output, 1, clear in progress.
REQ-010 SHALL have port we_i, input, 1, write strobe.
REQ-011 SHALL have port be_i, input, DW/8, byte enables for write.
REQ-012 SHALL have port waddr_i, input, clog2(SZ), write address.
REQ-013 SHALL have port wdata_i, input, DW, write data.
REQ-014 SHALL have port re_i, input, NRD, per-port read enable.
REQ-015 SHALL have port raddr_i, input, NRD*clog2(SZ), packed read addresses, port k at slice k.
REQ-016 SHALL have port rdata_o, output, NRD*DW, packed registered read data, port k at slice k.

Function
REQ-017 SHALL implement an FSM with states CLEAR and READY.
REQ-018 On reset release, state SHALL be CLEAR when CLRONRST=1, else READY.
REQ-019 CLEAR SHALL write zero to entry clrcnt each cycle, clrcnt 0..SZ-1, then go to READY: exactly SZ cycles.
REQ-020 busy_o SHALL be 1 exactly while in CLEAR.
REQ-021 clr_i=1 in READY SHALL enter CLEAR next cycle with clrcnt=0.
REQ-022 clr_i during CLEAR SHALL be ignored; the clear does not restart.
REQ-023 we_i during CLEAR SHALL be dropped; memory is not modified beyond zeroing.
REQ-024 In READY, we_i=1 SHALL update only bytes b of entry waddr_i where be_i[b]=1.
REQ-025 we_i=1 with be_i=0 SHALL leave memory unchanged.
REQ-026 Read latency SHALL be 1 cycle: re_i[k]=1 at edge n gives entry raddr_i[k] on rdata_o[k] after edge n.
REQ-027 re_i[k]=0 SHALL hold rdata_o[k] at its previous value.
REQ-028 Same-cycle read and write to the same address SHALL return the byte-merged new data (write-first), independently per port.
REQ-029 All NRD ports reading one address in one cycle SHALL return identical data.
REQ-030 Reads during CLEAR SHALL load zero into rdata_o[k] when re_i[k]=1.
REQ-031 Out-of-range addresses (>=SZ, SZ not a power of 2) SHALL be ignored on write and read as zero.

Reset
REQ-032 rst_i low SHALL asynchronously force rdata_o=0, clrcnt=0, and state to CLEAR (CLRONRST=1) or READY (CLRONRST=0).
REQ-033 Array contents SHALL NOT be reset; a reset during CLEAR restarts the clear from entry 0 after release.
REQ-034 busy_o SHALL equal CLRONRST while rst_i is low.

Structure
REQ-035 clog2 and the FSM state encodings SHALL come from the shared include lib/clog2.v plus a shared ram-states header; no local magic numbers.
REQ-036 Read-port register plus bypass merge SHALL be one sub-module, ramrdport, instantiated NRD times by generate.
REQ-037 The array SHALL be a single reg array inferable as distributed/block RAM with byte-write; no per-port copies.

Verification
REQ-038 SZ=16, CLRONRST=1, SRCFILE preset to all 0xFFFFFFFF; release reset -> busy_o=1 for exactly 16 cycles, then reads of all entries return 0.
REQ-039 Write 0x11223344 with be=0xF to addr 3, then be=0x2 with 0xAABBCCDD -> next read of addr 3 returns 0x1122CC44.
REQ-040 NRD=2; same cycle: write 0xDEADBEEF (be=0xF) to addr 5, port0 reads 5, port1 reads 6 (holding 0x0) -> rdata0=0xDEADBEEF, rdata1=0x0 one cycle later.
REQ-041 re_i=0 on port1 for 4 cycles while addr 7 is rewritten -> rdata_o[1] is unchanged throughout.
REQ-042 Assert clr_i, pulse rst_i low at clrcnt=8, release -> busy_o stays 1 for a further full 16 cycles, and we_i pulses inside that window have no effect.
REQ-043 clr_i held high through CLEAR -> completes in 16 cycles, READY for one cycle, re-enters CLEAR.

Source files
------------

// File: rtl/ram1clk1ino_pkg.sv
// Shared types and helpers for the single-clock multi-read RAM.
// State encoding and address-width helper live here only.
package ram1clk1ino_pkg;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } ram_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram1clk1ino_ramrdport.sv
// One registered read port with write-first byte merge.
// Zero forcing covers clearing and out-of-range addresses.
module ramrdport #(
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            re_i,
  input  logic            zero_i,
  input  logic            hit_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW-1:0]   mem_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] merged;

  always_comb begin
    merged = mem_i;
    for (int b = 0; b < DW/8; b++)
      if (hit_i && be_i[b])
        merged[b*8 +: 8] = wdata_i[b*8 +: 8];
    if (zero_i)
      merged = '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      rdata_o <= '0;
    else if (re_i)
      rdata_o <= merged;
  end

endmodule

// File: rtl/ram1clk1ino.sv
// Single-clock RAM: one byte-write port, NRD registered read
// ports, optional clear-after-reset and on-demand clear.
module ram1clk1ino
  import ram1clk1ino_pkg::*;
#(
  parameter int SZ       = 2,
  parameter int DW       = 32,
  parameter int NRD      = 2,
  parameter int CLRONRST = 1,
  parameter     SRCFILE  = ""
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  output logic                       busy_o,
  input  logic                       we_i,
  input  logic [DW/8-1:0]            be_i,
  input  logic [clog2(SZ)-1:0]       waddr_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic [NRD-1:0]             re_i,
  input  logic [NRD*clog2(SZ)-1:0]   raddr_i,
  output logic [NRD*DW-1:0]          rdata_o
);

  localparam int AW   = clog2(SZ);
  localparam int NB   = DW / 8;
  localparam bit POW2 = (SZ == (1 << AW));

  logic [DW-1:0] mem [SZ];

  ram_state_e    state_q, state_d;
  logic [AW-1:0] clrcnt_q, clrcnt_d;
  logic          clr_last;
  logic          waddr_ok;
  logic          wr_en;

  assign clr_last = (clrcnt_q == AW'(SZ - 1));

  if (POW2) begin : g_wp2
    assign waddr_ok = 1'b1;
  end else begin : g_wnp2
    assign waddr_ok = 32'(waddr_i) < 32'(SZ);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= (CLRONRST != 0) ? ST_CLEAR : ST_READY;
      clrcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      clrcnt_q <= clrcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clrcnt_d = '0;
    unique case (state_q)
      ST_CLEAR: begin
        clrcnt_d = clrcnt_q + 1'b1;
        if (clr_last) begin
          state_d  = ST_READY;
          clrcnt_d = '0;
        end
      end
      ST_READY: if (clr_i) state_d = ST_CLEAR;
      default:  state_d = ST_READY;
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_CLEAR);
  end

  assign wr_en = we_i && !busy_o && waddr_ok;

  // Contents are deliberately not reset; clearing walks one entry per cycle.
  always_ff @(posedge clk_i) begin
    if (busy_o)
      mem[clrcnt_q] <= '0;
    else if (wr_en)
      for (int b = 0; b < NB; b++)
        if (be_i[b])
          mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          ok;

    assign ra = raddr_i[k*AW +: AW];

    if (POW2) begin : g_rp2
      assign ok = 1'b1;
    end else begin : g_rnp2
      assign ok = 32'(ra) < 32'(SZ);
    end

    ramrdport #(
      .DW(DW)
    ) u_port (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .re_i    (re_i[k]),
      .zero_i  (busy_o || !ok),
      .hit_i   (wr_en && (waddr_i == ra)),
      .be_i    (be_i),
      .wdata_i (wdata_i),
      .mem_i   (mem[ra]),
      .rdata_o (rdata_o[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_ram1clk1ino.sv
// Directed bench for ram1clk1ino (SZ=16, DW=32, NRD=2).
// Inputs change and outputs are sampled on the falling edge.
module tb_ram1clk1ino;

  localparam int SZ  = 16;
  localparam int DW  = 32;
  localparam int NRD = 2;
  localparam int AW  = 4;

  logic              clk_i;
  logic              rst_i;
  logic              clr_i;
  logic              busy_o;
  logic              we_i;
  logic [3:0]        be_i;
  logic [AW-1:0]     waddr_i;
  logic [DW-1:0]     wdata_i;
  logic [NRD-1:0]    re_i;
  logic [NRD*AW-1:0] raddr_i;
  logic [NRD*DW-1:0] rdata_o;

  int checks;
  int failures;

  ram1clk1ino #(
    .SZ(SZ), .DW(DW), .NRD(NRD), .CLRONRST(1), .SRCFILE("")
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .busy_o  (busy_o),
    .we_i    (we_i),
    .be_i    (be_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .re_i    (re_i),
    .raddr_i (raddr_i),
    .rdata_o (rdata_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic idle();
    clr_i   = 1'b0;
    we_i    = 1'b0;
    be_i    = 4'h0;
    waddr_i = '0;
    wdata_i = '0;
    re_i    = '0;
    raddr_i = '0;
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy got=%b want=1", busy_o);
    end
    checks++;
    if (rdata_o !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h want=0", rdata_o);
    end
    rst_i = 1'b1;
    n = 0;
    while (busy_o === 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL reset_clear_len got=%0d want=16", n);
    end
  endtask

  task automatic test_read_all_zero();
    int bad;
    bad = 0;
    for (int i = 0; i < SZ; i++) begin
      idle();
      re_i    = 2'b11;
      raddr_i = {4'(SZ - 1 - i), 4'(i)};
      @(negedge clk_i);
      if (rdata_o !== 64'h0) bad++;
    end
    idle();
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL read_all_zero nonzero_reads=%0d want=0", bad);
    end
  endtask

  task automatic test_byte_write();
    idle();
    we_i = 1'b1; be_i = 4'hF; waddr_i = 4'd3; wdata_i = 32'h11223344;
    @(negedge clk_i);
    be_i = 4'h2; wdata_i = 32'hAABBCCDD;
    @(negedge clk_i);
    idle();
    re_i = 2'b01; raddr_i = {4'd0, 4'd3};
    @(negedge clk_i);
    checks++;
    if (rdata_o[31:0] !== 32'h1122CC44) begin
      failures++;
      $display("FAIL byte_write got=%h want=1122cc44", rdata_o[31:0]);
    end
    idle();
  endtask

  task automatic test_be_zero();
    idle();
    we_i = 1'b1; be_i = 4'h0; waddr_i = 4'd3; wdata_i = 32'hFFFFFFFF;
    @(negedge clk_i);
    idle();
    re_i = 2'b10; raddr_i = {4'd3, 4'd0};
    @(negedge clk_i);
    checks++;
    if (rdata_o[63:32] !== 32'h1122CC44) begin
      failures++;
      $display("FAIL be_zero got=%h want=1122cc44", rdata_o[63:32]);
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    we_i = 1'b1; be_i = 4'hF; waddr_i = 4'd5; wdata_i = 32'hDEADBEEF;
    re_i = 2'b11; raddr_i = {4'd6, 4'd5};
    @(negedge clk_i);
    checks++;
    if (rdata_o[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_p0 got=%h want=deadbeef", rdata_o[31:0]);
    end
    checks++;
    if (rdata_o[63:32] !== 32'h0) begin
      failures++;
      $display("FAIL bypass_p1 got=%h want=0", rdata_o[63:32]);
    end
    be_i = 4'h1; wdata_i = 32'h000000AA;
    raddr_i = {4'd5, 4'd5};
    @(negedge clk_i);
    checks++;
    if (rdata_o !== {32'hDEADBEAA, 32'hDEADBEAA}) begin
      failures++;
      $display("FAIL bypass_merge got=%h want=deadbeaadeadbeaa", rdata_o);
    end
    idle();
  endtask

  task automatic test_hold();
    int bad;
    idle();
    re_i = 2'b10; raddr_i = {4'd5, 4'd0};
    @(negedge clk_i);
    checks++;
    if (rdata_o[63:32] !== 32'hDEADBEAA) begin
      failures++;
      $display("FAIL hold_setup got=%h want=deadbeaa", rdata_o[63:32]);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      we_i = 1'b1; be_i = 4'hF; waddr_i = 4'd7;
      wdata_i = 32'h7070_0000 + 32'(i);
      re_i = 2'b00; raddr_i = {4'd7, 4'd7};
      @(negedge clk_i);
      if (rdata_o[63:32] !== 32'hDEADBEAA) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_p1 changed_cycles=%0d want=0", bad);
    end
    idle();
    re_i = 2'b01; raddr_i = {4'd0, 4'd7};
    @(negedge clk_i);
    checks++;
    if (rdata_o[31:0] !== 32'h70700003) begin
      failures++;
      $display("FAIL hold_last_write got=%h want=70700003", rdata_o[31:0]);
    end
    idle();
  endtask

  task automatic test_clear_reset();
    int n;
    int bad;
    idle();
    clr_i = 1'b1;
    @(negedge clk_i);
    idle();
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL clr_enter got=%b want=1", busy_o);
    end
    repeat (8) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b1 || rdata_o !== 64'h0) begin
      failures++;
      $display("FAIL clr_rst_async busy=%b rdata=%h want busy=1 rdata=0",
               busy_o, rdata_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    n = 0;
    bad = 0;
    while (busy_o === 1'b1 && n < 40) begin
      we_i = 1'b1; be_i = 4'hF; waddr_i = 4'd2;
      wdata_i = 32'h12345678;
      re_i = 2'b01; raddr_i = {4'd0, 4'd2};
      @(negedge clk_i);
      if (busy_o === 1'b1 && rdata_o[31:0] !== 32'h0) bad++;
      n++;
    end
    idle();
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL clr_restart_len got=%0d want=16", n);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clr_read_zero nonzero=%0d want=0", bad);
    end
    re_i = 2'b11; raddr_i = {4'd3, 4'd2};
    @(negedge clk_i);
    checks++;
    if (rdata_o !== 64'h0) begin
      failures++;
      $display("FAIL clr_contents got=%h want=0", rdata_o);
    end
    idle();
  endtask

  task automatic test_clr_held();
    int n;
    idle();
    clr_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL held_enter got=%b want=1", busy_o);
    end
    n = 0;
    while (busy_o === 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL held_len got=%0d want=16", n);
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL held_reenter got=%b want=1", busy_o);
    end
    clr_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL held_finish got=%b want=0", busy_o);
    end
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_i    = 1'b0;
    idle();
    test_reset();
    test_read_all_zero();
    test_byte_write();
    test_be_zero();
    test_bypass();
    test_hold();
    test_clear_reset();
    test_clr_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
